// File: rtl/dsp_mac_pipe_if.sv
// rtl/dsp_mac_pipe_if.sv - beat inputs and accumulator outputs of dsp_mac_pipe
interface dsp_mac_pipe_if #(
  parameter int A_W = 18,
  parameter int B_W = 18,
  parameter int P_W = 48
);
  logic                  IN_VALID;
  logic signed [A_W-1:0] A;
  logic signed [B_W-1:0] B;
  logic signed [B_W-1:0] D;
  logic signed [P_W-1:0] C;
  logic [3:0]            OPMODE;
  logic                  ACC_CLR;
  logic                  OUT_VALID;
  logic signed [P_W-1:0] P;
  logic                  CARRYOUT;
  logic                  OVF;
  logic                  PATTERN_DET;

  modport master (
    output IN_VALID, A, B, D, C, OPMODE, ACC_CLR,
    input  OUT_VALID, P, CARRYOUT, OVF, PATTERN_DET
  );

  modport slave (
    input  IN_VALID, A, B, D, C, OPMODE, ACC_CLR,
    output OUT_VALID, P, CARRYOUT, OVF, PATTERN_DET
  );
endinterface

// File: rtl/dsp_mac_pipe.sv
// rtl/dsp_mac_pipe.sv - signed pre-add/multiply/accumulate pipeline with saturation and pattern detect
module dsp_mac_pipe #(
  parameter int             A_W      = 18,
  parameter int             B_W      = 18,
  parameter int             P_W      = 48,
  parameter int             IN_REG   = 1,
  parameter int             MREG     = 1,
  parameter int             SATURATE = 0,
  parameter logic [P_W-1:0] PATTERN  = '0
) (
  input  logic          clk,
  input  logic          RST,
  input  logic          CE,
  dsp_mac_pipe_if.slave bus
);
  localparam int M_W = A_W + B_W + 1;
  localparam logic signed [P_W-1:0] P_MAX = {1'b0, {(P_W-1){1'b1}}};
  localparam logic signed [P_W-1:0] P_MIN = {1'b1, {(P_W-1){1'b0}}};

  // stage 1: operands, OPMODE and C of the beat
  logic signed [A_W-1:0] a1;
  logic signed [B_W-1:0] b1;
  logic signed [B_W-1:0] d1;
  logic signed [P_W-1:0] c1;
  logic [3:0]            op1;
  logic                  v1;

  generate
    if (IN_REG != 0) begin : g_in_reg
      always_ff @(posedge clk) begin
        if (RST) begin
          a1  <= '0;
          b1  <= '0;
          d1  <= '0;
          c1  <= '0;
          op1 <= '0;
          v1  <= 1'b0;
        end else if (CE) begin
          a1  <= bus.A;
          b1  <= bus.B;
          d1  <= bus.D;
          c1  <= bus.C;
          op1 <= bus.OPMODE;
          v1  <= bus.IN_VALID;
        end
      end
    end else begin : g_in_pass
      assign a1  = bus.A;
      assign b1  = bus.B;
      assign d1  = bus.D;
      assign c1  = bus.C;
      assign op1 = bus.OPMODE;
      assign v1  = bus.IN_VALID;
    end
  endgenerate

  logic signed [B_W:0]   pre;
  logic signed [M_W-1:0] prod;

  always_comb begin
    pre = (B_W+1)'(b1);
    if (op1[0]) begin
      if (op1[1]) pre = (B_W+1)'(d1) - (B_W+1)'(b1);
      else        pre = (B_W+1)'(d1) + (B_W+1)'(b1);
    end
    prod = M_W'(a1) * M_W'(pre);
  end

  // stage 2: product with the C/OPMODE of the same beat
  logic signed [M_W-1:0] m2;
  logic signed [P_W-1:0] c2;
  logic [3:0]            op2;
  logic                  v2;

  generate
    if (MREG != 0) begin : g_m_reg
      always_ff @(posedge clk) begin
        if (RST) begin
          m2  <= '0;
          c2  <= '0;
          op2 <= '0;
          v2  <= 1'b0;
        end else if (CE) begin
          m2  <= prod;
          c2  <= c1;
          op2 <= op1;
          v2  <= v1;
        end
      end
    end else begin : g_m_pass
      assign m2  = prod;
      assign c2  = c1;
      assign op2 = op1;
      assign v2  = v1;
    end
  endgenerate

  logic signed [P_W-1:0] p_q;
  logic                  carry_q;
  logic                  ovf_q;
  logic                  vld_q;
  logic                  pdet_q;

  logic signed [P_W-1:0] m_ext;
  logic signed [P_W-1:0] z;
  logic signed [P_W:0]   s_sgn;
  logic [P_W:0]          s_uns;
  logic                  ovf_now;
  logic signed [P_W-1:0] p_next;

  // s_sgn carries the true signed result, s_uns the unsigned carry/borrow
  always_comb begin
    m_ext = P_W'(m2);
    if (bus.ACC_CLR)  z = '0;
    else if (op2[2])  z = p_q;
    else              z = c2;
    if (op2[3]) begin
      s_sgn = (P_W+1)'(z) - (P_W+1)'(m_ext);
      s_uns = {1'b0, z} - {1'b0, m_ext};
    end else begin
      s_sgn = (P_W+1)'(z) + (P_W+1)'(m_ext);
      s_uns = {1'b0, z} + {1'b0, m_ext};
    end
    ovf_now = s_sgn[P_W] ^ s_sgn[P_W-1];
    p_next  = s_sgn[P_W-1:0];
    if ((SATURATE != 0) && ovf_now) p_next = s_sgn[P_W] ? P_MIN : P_MAX;
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      p_q     <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      vld_q   <= 1'b0;
      pdet_q  <= (PATTERN == '0);
    end else if (CE) begin
      vld_q <= v2;
      if (v2) begin
        p_q     <= p_next;
        carry_q <= s_uns[P_W];
        ovf_q   <= (bus.ACC_CLR ? 1'b0 : ovf_q) | ovf_now;
        pdet_q  <= (p_next == PATTERN);
      end else if (bus.ACC_CLR) begin
        p_q    <= '0;
        ovf_q  <= 1'b0;
        pdet_q <= (PATTERN == '0);
      end
    end
  end

  assign bus.P           = p_q;
  assign bus.CARRYOUT    = carry_q;
  assign bus.OVF         = ovf_q;
  assign bus.OUT_VALID   = vld_q;
  assign bus.PATTERN_DET = pdet_q;
endmodule
